sar_comp_model: RTL and testbench

Cycle-accurate behavioural model of the SAR ADC's dynamic comparator: the responder end of the `outp`/`outn` decision interface consumed by the `shiftr` SAR shift-register logic. On `start`, it runs N precharge/evaluate decision cycles. Each decision compares a target code `vin` (plus a modelled offset) against the trial DAC code `clc` presented by the SAR logic. It then captures the final code and flags whether the loop converged. It sits in the conversion test environment opposite `shiftr` and closes the SAR loop without analogue models.

---
 rtl/sar_comp_model_if.sv | 27 ++
 rtl/sar_comp_model.sv | 171 +++++++++++++++++
 tb/tb_sar_comp_model.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sar_comp_model_if.sv
// rtl/sar_comp_model_if.sv - decision interface between SAR logic and comparator model
interface sar_comp_model_if #(
  parameter int N = 10
);
  logic         start;
  logic [N-1:0] vin;
  logic [N-1:0] clc;
  logic         creset;
  logic         outp;
  logic         outn;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         match;

  // SAR logic / test environment side
  modport master (
    output start, vin, clc, creset,
    input  outp, outn, busy, done, result, match
  );

  // comparator model side
  modport slave (
    input  start, vin, clc, creset,
    output outp, outn, busy, done, result, match
  );
endinterface

// File: rtl/sar_comp_model.sv
// rtl/sar_comp_model.sv - cycle-accurate dynamic comparator model closing the SAR loop
module sar_comp_model #(
  parameter int N        = 10,
  parameter int PRE_CYC  = 2,
  parameter int EVAL_CYC = 5,
  parameter int OFFSET   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sar_comp_model_if.slave  cmp
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_EVAL, S_FINAL} state_t;

  localparam int PMAX = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int BW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0]       PRE_LAST  = PW'(PRE_CYC - 1);
  localparam logic [PW-1:0]       EVAL_LAST = PW'(EVAL_CYC - 1);
  localparam logic [BW-1:0]       BIT_TOP   = BW'(N - 1);
  localparam logic signed [N+1:0] OFS       = (N+2)'(OFFSET);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          last_q, last_d;    // all N decisions have been made
  logic [N-1:0]  vin_q, vin_d;
  logic          outp_q, outp_d;
  logic          outn_q, outn_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  result_q, result_d;
  logic          match_q, match_d;

  logic signed [N+1:0] veff;
  logic [N-1:0]        vexp;
  logic                keep;

  // Effective input: latched code plus offset, clamped into the code range
  always_comb begin
    veff = $signed({2'b00, vin_q}) + OFS;
    if (veff[N+1]) begin
      vexp = '0;
    end else if (veff[N]) begin
      vexp = '1;
    end else begin
      vexp = veff[N-1:0];
    end
    keep = (vexp >= cmp.clc);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      bit_q    <= BIT_TOP;
      last_q   <= 1'b0;
      vin_q    <= '0;
      outp_q   <= 1'b1;
      outn_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      vin_q    <= vin_d;
      outp_q   <= outp_d;
      outn_q   <= outn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      match_q  <= match_d;
    end
  end

  // Next state: creset aborts any active conversion, and beats start in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmp.start && !cmp.creset) state_d = S_PRE;
      S_PRE:   if (phase_q == PRE_LAST) state_d = last_q ? S_FINAL : S_EVAL;
      S_EVAL:  if (phase_q == EVAL_LAST) state_d = S_PRE;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && cmp.creset) state_d = S_IDLE;
  end

  // Output and counter next values, registered one cycle ahead of use
  always_comb begin
    phase_d  = phase_q;
    bit_d    = bit_q;
    last_d   = last_q;
    vin_d    = vin_q;
    outp_d   = 1'b1;
    outn_d   = 1'b1;
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;
    result_d = result_q;
    match_d  = match_q;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        bit_d   = BIT_TOP;
        last_d  = 1'b0;
        if (state_d == S_PRE) vin_d = cmp.vin;
      end
      S_PRE: begin
        if (phase_q == PRE_LAST) begin
          phase_d = '0;
          if (last_q) begin
            // trailing precharge: the SAR code is final, capture it
            result_d = cmp.clc;
            match_d  = (cmp.clc == vexp);
            done_d   = 1'b1;
          end else begin
            outp_d = keep;
            outn_d = !keep;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_EVAL: begin
        // decision is held from the registers; clc is ignored here
        outp_d = outp_q;
        outn_d = outn_q;
        if (phase_q == EVAL_LAST) begin
          phase_d = '0;
          outp_d  = 1'b1;
          outn_d  = 1'b1;
          if (bit_q == '0) last_d = 1'b1;
          else             bit_d  = bit_q - BW'(1);
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_FINAL: begin
        phase_d = '0;
        bit_d   = BIT_TOP;
        last_d  = 1'b0;
      end
      default: begin
        phase_d = '0;
      end
    endcase
    if (state_q != S_IDLE && cmp.creset) begin
      outp_d   = 1'b1;
      outn_d   = 1'b1;
      done_d   = 1'b0;
      result_d = result_q;
      match_d  = match_q;
      phase_d  = '0;
      bit_d    = BIT_TOP;
      last_d   = 1'b0;
    end
  end

  assign cmp.outp   = outp_q;
  assign cmp.outn   = outn_q;
  assign cmp.busy   = busy_q;
  assign cmp.done   = done_q;
  assign cmp.result = result_q;
  assign cmp.match  = match_q;

endmodule

// File: tb/tb_sar_comp_model.sv
// tb/tb_sar_comp_model.sv - randomized self-checking bench for sar_comp_model
module tb_sar_comp_model;
  localparam int N      = 10;
  localparam int PRE    = 2;
  localparam int EVAL   = 5;
  localparam int SLOT   = PRE + EVAL;
  localparam int DONE_C = N * SLOT + PRE + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_comp_model_if #(.N(N)) if_a ();
  sar_comp_model_if #(.N(N)) if_b ();

  sar_comp_model #(.N(N), .PRE_CYC(PRE), .EVAL_CYC(EVAL), .OFFSET(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmp(if_a.slave)
  );
  sar_comp_model #(.N(N), .PRE_CYC(PRE), .EVAL_CYC(EVAL), .OFFSET(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmp(if_b.slave)
  );

  int           sel = 0;
  logic         start_v = 1'b0;
  logic         creset_v = 1'b0;
  logic [N-1:0] vin_v = '0;
  logic [N-1:0] clc_v = '0;

  assign if_a.start  = (sel == 0) ? start_v  : 1'b0;
  assign if_a.creset = (sel == 0) ? creset_v : 1'b0;
  assign if_a.vin    = (sel == 0) ? vin_v    : '0;
  assign if_a.clc    = (sel == 0) ? clc_v    : '0;
  assign if_b.start  = (sel == 1) ? start_v  : 1'b0;
  assign if_b.creset = (sel == 1) ? creset_v : 1'b0;
  assign if_b.vin    = (sel == 1) ? vin_v    : '0;
  assign if_b.clc    = (sel == 1) ? clc_v    : '0;

  wire [1:0]   o_pair   = (sel == 1) ? {if_b.outp, if_b.outn} : {if_a.outp, if_a.outn};
  wire         o_busy   = (sel == 1) ? if_b.busy   : if_a.busy;
  wire         o_done   = (sel == 1) ? if_b.done   : if_a.done;
  wire [N-1:0] o_result = (sel == 1) ? if_b.result : if_a.result;
  wire         o_match  = (sel == 1) ? if_b.match  : if_a.match;

  int total = 0;
  int bad = 0;
  int last_res [2] = '{0, 0};
  int last_match [2] = '{0, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_code(input int v, input int ofs);
    int e;
    e = v + ofs;
    if (e < 0) e = 0;
    if (e > (1 << N) - 1) e = (1 << N) - 1;
    return e;
  endfunction

  // One conversion on DUT s; abort_kind 1 = creset, 2 = rst_n, asserted in cycle abort_c
  task automatic run_conv(input int s, input logic [N-1:0] vin, input int ofs, input bit ideal,
                          input logic [N-1:0] fixed_clc, input int abort_kind, input int abort_c);
    int ecode, slot, pos, c_end, eres, emat;
    logic [N-1:0] code, bitm;
    logic [1:0] ep;
    bit eb, ed, keep, aborted;
    ecode = exp_code(int'(vin), ofs);
    eres  = ideal ? ecode : int'(fixed_clc);
    emat  = (eres == ecode) ? 1 : 0;
    sel   = s;
    code  = ideal ? (N)'(1 << (N - 1)) : fixed_clc;
    clc_v = code;
    vin_v = vin;
    start_v = 1'b1;
    creset_v = 1'b0;
    @(posedge clk);
    c_end = (abort_kind != 0) ? abort_c + 3 : DONE_C + 1;
    for (int c = 1; c <= c_end; c++) begin
      @(negedge clk);
      slot = (c - 1) / SLOT;
      pos  = (c - 1) % SLOT;
      aborted = (abort_kind != 0) && (c > abort_c);
      if (aborted) begin
        ep = 2'b11; eb = 1'b0; ed = 1'b0;
      end else begin
        eb = (c <= DONE_C);
        ed = (c == DONE_C);
        if (slot < N && pos >= PRE) begin
          keep = ideal ? ecode[N-1-slot] : (ecode >= int'(fixed_clc));
          ep = keep ? 2'b10 : 2'b01;
        end else begin
          ep = 2'b11;
        end
      end
      check_eq($sformatf("pair d%0d c=%0d", s, c), o_pair, ep);
      check_eq($sformatf("busy d%0d c=%0d", s, c), o_busy, eb);
      check_eq($sformatf("done d%0d c=%0d", s, c), o_done, ed);
      if (ed) begin
        last_res[s] = eres;
        last_match[s] = emat;
      end
      if (aborted && c == abort_c + 1 && abort_kind == 2) begin
        last_res = '{0, 0};
        last_match = '{0, 0};
      end
      if (ed || (!aborted && c == DONE_C + 1) || (aborted && c == abort_c + 1)) begin
        check_eq($sformatf("result d%0d c=%0d", s, c), o_result, last_res[s]);
        check_eq($sformatf("match d%0d c=%0d", s, c), o_match, last_match[s]);
      end
      // inputs for the edge closing this cycle
      vin_v   = N'($urandom);
      start_v = (c == 10);
      if (ideal && slot < N && pos == PRE) begin
        bitm = N'(1 << (N - 1 - slot));
        if (!o_pair[1]) code = code & ~bitm;
        if (slot < N - 1) code = code | (bitm >> 1);
        clc_v = code;
      end else if (!ideal && slot < N && pos >= PRE) begin
        clc_v = (pos == SLOT - 1) ? fixed_clc : N'($urandom);
      end
      creset_v = (abort_kind == 1 && c == abort_c);
      rst_n    = !(abort_kind == 2 && c == abort_c);
    end
    start_v = 1'b0;
    creset_v = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst pair a", {if_a.outp, if_a.outn}, 2'b11);
    check_eq("rst busy a", if_a.busy, 1'b0);
    check_eq("rst done a", if_a.done, 1'b0);
    check_eq("rst result a", if_a.result, 0);
    check_eq("rst match a", if_a.match, 1'b0);
    check_eq("rst pair b", {if_b.outp, if_b.outn}, 2'b11);
    check_eq("rst result b", if_b.result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(0, 10'h2A5, 0, 1'b1, '0, 0, 0);
    run_conv(0, 10'h1FF, 0, 1'b0, 10'h200, 0, 0);
    run_conv(0, 10'h200, 0, 1'b0, 10'h200, 0, 0);
    run_conv(1, 10'h3FC, 8, 1'b1, '0, 0, 0);
    run_conv(1, 10'h3FF, 8, 1'b1, '0, 0, 0);
    run_conv(1, 10'h000, 8, 1'b1, '0, 0, 0);

    run_conv(0, N'($urandom), 0, 1'b1, '0, 1, 26);
    run_conv(0, N'($urandom), 0, 1'b1, '0, 0, 0);

    // start together with creset in IDLE must not begin a conversion
    start_v = 1'b1;
    creset_v = 1'b1;
    vin_v = 10'h155;
    @(negedge clk);
    start_v = 1'b0;
    creset_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("sc busy %0d", i), o_busy, 1'b0);
      check_eq($sformatf("sc pair %0d", i), o_pair, 2'b11);
      check_eq($sformatf("sc done %0d", i), o_done, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      int s;
      s = int'($urandom_range(0, 1));
      run_conv(s, N'($urandom), (s == 1) ? 8 : 0, 1'($urandom_range(0, 1)), N'($urandom), 0, 0);
    end

    run_conv(1, N'($urandom), 8, 1'b1, '0, 2, 40);
    run_conv(1, N'($urandom), 8, 1'b1, '0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
